// File: rtl/uart_cfg.sv
// uart_cfg: runtime-configurable UART core (5-8 data bits, none/even/odd
// parity, 1 or 2 stop bits) with show-ahead RX and TX FIFOs, per-character
// error flags, sticky RX overrun and FIFO fill levels.

module uart_cfg_fifo #(
    parameter int W      = 8,
    parameter int FIFO_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [W-1:0]    wdata,
    output logic [W-1:0]    rdata,
    output logic            full,
    output logic            empty,
    output logic [FIFO_W:0] level
);
    localparam int DEPTH = 1 << FIFO_W;

    logic [W-1:0]      mem [DEPTH];
    logic [FIFO_W-1:0] wr_ptr;
    logic [FIFO_W-1:0] rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (level == (FIFO_W+1)'(DEPTH));
    assign empty   = (level == '0);
    assign pop_ok  = pop && !empty;
    // A push into a full FIFO is still taken when a pop frees a slot that cycle.
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    // Storage array: data words carry no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally modulo the depth; level tracks occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + (FIFO_W+1)'(push_ok) - (FIFO_W+1)'(pop_ok);
        end
    end
endmodule

module uart_cfg #(
    parameter int FIFO_W = 4,
    parameter int DVSR_W = 11,
    parameter int OVS    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic [1:0]        data_bits,
    input  logic [1:0]        parity,
    input  logic              stop2,
    input  logic              wr_uart,
    input  logic [7:0]        w_data,
    input  logic              rd_uart,
    input  logic              clr_err,
    input  logic              rx,
    output logic [7:0]        r_data,
    output logic              r_parity_err,
    output logic              r_frame_err,
    output logic              rx_empty,
    output logic              rx_full,
    output logic [FIFO_W:0]   rx_level,
    output logic              rx_overrun,
    output logic              tx_full,
    output logic              tx_empty,
    output logic [FIFO_W:0]   tx_level,
    output logic              tx_busy,
    output logic              tx
);
    // Tick counter must reach 2*OVS-1 for a double stop bit.
    localparam int SW = $clog2(2 * OVS);
    localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_FULL = SW'(OVS - 1);
    localparam logic [SW-1:0] S_DBL  = SW'(2 * OVS - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

    logic [DVSR_W-1:0] baud_cnt;
    logic              tick;
    logic              rx_meta, rx_sync;

    rx_state_t   rx_state, rx_state_n;
    logic [SW-1:0] rx_s, rx_s_n;
    logic [2:0]  rx_n, rx_n_n, rx_last, rx_last_n;
    logic [7:0]  rx_b, rx_b_n;
    logic        rx_acc, rx_acc_n, rx_perr, rx_perr_n;
    logic [1:0]  rx_pmode, rx_pmode_n;
    logic        rx_push;
    logic [9:0]  rx_head;

    tx_state_t   tx_state, tx_state_n;
    logic [SW-1:0] tx_s, tx_s_n;
    logic [2:0]  tx_n, tx_n_n, tx_last, tx_last_n;
    logic [7:0]  tx_b, tx_b_n;
    logic        tx_pbit, tx_pbit_n, tx_pen, tx_pen_n, tx_st2, tx_st2_n;
    logic        tx_reg, tx_reg_n;
    logic        tx_pop;
    logic [7:0]  tx_head;
    logic [7:0]  len_mask;

    // Baud generator: counts 0..dvsr and ticks for one clock on the wrap.
    assign tick = (baud_cnt == dvsr);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) baud_cnt <= '0;
        else       baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
    end

    // Two-flop synchroniser on the serial input, preset to the idle level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // RX state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_s     <= '0;
            rx_n     <= '0;
            rx_b     <= '0;
            rx_acc   <= 1'b0;
            rx_perr  <= 1'b0;
            rx_last  <= 3'd7;
            rx_pmode <= 2'b00;
        end else begin
            rx_state <= rx_state_n;
            rx_s     <= rx_s_n;
            rx_n     <= rx_n_n;
            rx_b     <= rx_b_n;
            rx_acc   <= rx_acc_n;
            rx_perr  <= rx_perr_n;
            rx_last  <= rx_last_n;
            rx_pmode <= rx_pmode_n;
        end
    end

    // RX next state: mid-bit sampling, config latched once the start bit is confirmed.
    always_comb begin
        rx_state_n = rx_state;
        rx_s_n     = rx_s;
        rx_n_n     = rx_n;
        rx_b_n     = rx_b;
        rx_acc_n   = rx_acc;
        rx_perr_n  = rx_perr;
        rx_last_n  = rx_last;
        rx_pmode_n = rx_pmode;
        rx_push    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_sync) begin
                    rx_state_n = RX_START;
                    rx_s_n     = '0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_s == S_HALF) begin
                        if (rx_sync) begin
                            rx_state_n = RX_IDLE;
                        end else begin
                            rx_state_n = RX_DATA;
                            rx_s_n     = '0;
                            rx_n_n     = '0;
                            rx_b_n     = '0;
                            rx_acc_n   = 1'b0;
                            rx_perr_n  = 1'b0;
                            rx_last_n  = 3'd4 + {1'b0, data_bits};
                            rx_pmode_n = parity;
                        end
                    end else begin
                        rx_s_n = rx_s + 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (rx_s == S_FULL) begin
                        rx_s_n       = '0;
                        rx_b_n[rx_n] = rx_sync;
                        rx_acc_n     = rx_acc ^ rx_sync;
                        if (rx_n == rx_last) rx_state_n = (^rx_pmode) ? RX_PAR : RX_STOP;
                        else                 rx_n_n     = rx_n + 1'b1;
                    end else begin
                        rx_s_n = rx_s + 1'b1;
                    end
                end
            end
            RX_PAR: begin
                if (tick) begin
                    if (rx_s == S_FULL) begin
                        rx_s_n     = '0;
                        // Even: total ones must be even; odd mode inverts the test.
                        rx_perr_n  = rx_acc ^ rx_sync ^ rx_pmode[1];
                        rx_state_n = RX_STOP;
                    end else begin
                        rx_s_n = rx_s + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (rx_s == S_FULL) begin
                        rx_push    = 1'b1;
                        // A low stop bit may be a break: wait for the line to go high.
                        rx_state_n = rx_sync ? RX_IDLE : RX_WAIT;
                    end else begin
                        rx_s_n = rx_s + 1'b1;
                    end
                end
            end
            RX_WAIT: begin
                if (rx_sync) rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    uart_cfg_fifo #(.W(10), .FIFO_W(FIFO_W)) rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (rd_uart),
        .wdata ({~rx_sync, rx_perr, rx_b}),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    assign r_data       = rx_empty ? 8'h00 : rx_head[7:0];
    assign r_parity_err = rx_empty ? 1'b0  : rx_head[8];
    assign r_frame_err  = rx_empty ? 1'b0  : rx_head[9];

    // Sticky overrun: a push into a full FIFO with no simultaneous read; set wins over clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                              rx_overrun <= 1'b0;
        else if (rx_push && rx_full && !rd_uart) rx_overrun <= 1'b1;
        else if (clr_err)                       rx_overrun <= 1'b0;
    end

    uart_cfg_fifo #(.W(8), .FIFO_W(FIFO_W)) tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_uart),
        .pop   (tx_pop),
        .wdata (w_data),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    assign len_mask = 8'hFF >> (~data_bits);
    assign tx_busy  = (tx_state != TX_IDLE);
    assign tx       = tx_reg;

    // TX state, datapath and registered serial output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_s     <= '0;
            tx_n     <= '0;
            tx_b     <= '0;
            tx_pbit  <= 1'b0;
            tx_pen   <= 1'b0;
            tx_st2   <= 1'b0;
            tx_last  <= 3'd7;
            tx_reg   <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_s     <= tx_s_n;
            tx_n     <= tx_n_n;
            tx_b     <= tx_b_n;
            tx_pbit  <= tx_pbit_n;
            tx_pen   <= tx_pen_n;
            tx_st2   <= tx_st2_n;
            tx_last  <= tx_last_n;
            tx_reg   <= tx_reg_n;
        end
    end

    // TX next state: head stays in the FIFO until its stop bit(s) complete.
    always_comb begin
        tx_state_n = tx_state;
        tx_s_n     = tx_s;
        tx_n_n     = tx_n;
        tx_b_n     = tx_b;
        tx_pbit_n  = tx_pbit;
        tx_pen_n   = tx_pen;
        tx_st2_n   = tx_st2;
        tx_last_n  = tx_last;
        tx_reg_n   = tx_reg;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_reg_n = 1'b1;
                if (!tx_empty) begin
                    tx_state_n = TX_START;
                    tx_s_n     = '0;
                    tx_b_n     = tx_head;
                    tx_pbit_n  = (^(tx_head & len_mask)) ^ parity[1];
                    tx_pen_n   = ^parity;
                    tx_st2_n   = stop2;
                    tx_last_n  = 3'd4 + {1'b0, data_bits};
                    tx_reg_n   = 1'b0;
                end
            end
            TX_START: begin
                if (tick) begin
                    if (tx_s == S_FULL) begin
                        tx_s_n     = '0;
                        tx_n_n     = '0;
                        tx_state_n = TX_DATA;
                        tx_reg_n   = tx_b[0];
                    end else begin
                        tx_s_n = tx_s + 1'b1;
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (tx_s == S_FULL) begin
                        tx_s_n = '0;
                        tx_b_n = {1'b0, tx_b[7:1]};
                        if (tx_n == tx_last) begin
                            tx_state_n = tx_pen ? TX_PAR : TX_STOP;
                            tx_reg_n   = tx_pen ? tx_pbit : 1'b1;
                        end else begin
                            tx_n_n   = tx_n + 1'b1;
                            tx_reg_n = tx_b[1];
                        end
                    end else begin
                        tx_s_n = tx_s + 1'b1;
                    end
                end
            end
            TX_PAR: begin
                if (tick) begin
                    if (tx_s == S_FULL) begin
                        tx_s_n     = '0;
                        tx_state_n = TX_STOP;
                        tx_reg_n   = 1'b1;
                    end else begin
                        tx_s_n = tx_s + 1'b1;
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (tx_s == (tx_st2 ? S_DBL : S_FULL)) begin
                        tx_state_n = TX_IDLE;
                        tx_pop     = 1'b1;
                    end else begin
                        tx_s_n = tx_s + 1'b1;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_cfg.sv
// Directed testbench for uart_cfg: 8N1 waveform, 7E1 loopback, parity and
// framing errors, FIFO full/overrun, stop2 spacing, mid-frame reset, glitch.
`timescale 1ns/1ps
module tb_uart_cfg;
    localparam int FIFO_W = 2;
    localparam int DVSR_W = 11;
    localparam int OVS    = 16;

    logic              clk;
    logic              reset;
    logic [DVSR_W-1:0] dvsr;
    logic [1:0]        data_bits;
    logic [1:0]        parity;
    logic              stop2;
    logic              wr_uart;
    logic [7:0]        w_data;
    logic              rd_uart;
    logic              clr_err;
    logic              rx_drv;
    logic              loop;
    logic              rx_in;
    logic [7:0]        r_data;
    logic              r_parity_err;
    logic              r_frame_err;
    logic              rx_empty;
    logic              rx_full;
    logic [FIFO_W:0]   rx_level;
    logic              rx_overrun;
    logic              tx_full;
    logic              tx_empty;
    logic [FIFO_W:0]   tx_level;
    logic              tx_busy;
    logic              tx;

    int checks = 0;
    int errors = 0;
    int b0, b1, run, maxrun, lim;
    logic [9:0] got;
    logic tr_tx   [0:399];
    logic tr_busy [0:399];
    logic [FIFO_W:0] tr_lvl [0:399];

    assign rx_in = loop ? tx : rx_drv;

    uart_cfg #(.FIFO_W(FIFO_W), .DVSR_W(DVSR_W), .OVS(OVS)) dut (
        .clk(clk), .reset(reset), .dvsr(dvsr), .data_bits(data_bits), .parity(parity),
        .stop2(stop2), .wr_uart(wr_uart), .w_data(w_data), .rd_uart(rd_uart),
        .clr_err(clr_err), .rx(rx_in), .r_data(r_data), .r_parity_err(r_parity_err),
        .r_frame_err(r_frame_err), .rx_empty(rx_empty), .rx_full(rx_full),
        .rx_level(rx_level), .rx_overrun(rx_overrun), .tx_full(tx_full),
        .tx_empty(tx_empty), .tx_level(tx_level), .tx_busy(tx_busy), .tx(tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_tx(input logic [7:0] d);
        w_data  = d;
        wr_uart = 1'b1;
        step();
        wr_uart = 1'b0;
    endtask

    task automatic read_rx();
        rd_uart = 1'b1;
        step();
        rd_uart = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        rx_drv = b;
        repeat (OVS) step();
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic has_par,
                              input logic pbit, input logic stopb);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
        if (has_par) send_bit(pbit);
        send_bit(stopb);
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            tr_tx[i]   = tx;
            tr_busy[i] = tx_busy;
            tr_lvl[i]  = tx_level;
            step();
        end
    endtask

    task automatic wait_tx_idle(input int limit);
        for (int i = 0; i < limit && !(tx_empty && !tx_busy); i++) step();
        check("tx_idle_wait", 32'(tx_empty && !tx_busy), 32'd1);
    endtask

    initial begin
        reset = 1'b1; dvsr = '0; data_bits = 2'b11; parity = 2'b00; stop2 = 1'b0;
        wr_uart = 1'b0; w_data = 8'h00; rd_uart = 1'b0; clr_err = 1'b0;
        rx_drv = 1'b1; loop = 1'b0;
        step();
        // Reset state
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_flags", 32'({tx_busy, rx_overrun, rx_empty, tx_empty, rx_full, tx_full}), 32'b001100);
        check("rst_levels", 32'({rx_level, tx_level}), 32'd0);
        check("rst_rhead", 32'({r_frame_err, r_parity_err, r_data}), 32'd0);
        reset = 1'b0;
        repeat (3) step();

        // 8N1 0xA5 waveform and frame length
        write_tx(8'hA5);
        capture(200);
        b0 = -1; b1 = -1;
        for (int i = 0; i < 200; i++) begin
            if (b0 < 0 && tr_busy[i]) b0 = i;
            if (b0 >= 0 && b1 < 0 && !tr_busy[i]) b1 = i;
        end
        check("t1_busy_len", 32'(b1 - b0), 32'd160);
        got = '0;
        if (b0 >= 0) for (int k = 0; k < 10; k++) got[k] = tr_tx[b0 + 8 + 16 * k];
        check("t1_tx_bits", 32'(got), 32'({1'b1, 8'hA5, 1'b0}));
        if (b1 > 0) begin
            check("t1_lvl_before_end", 32'(tr_lvl[b1 - 1]), 32'd1);
            check("t1_lvl_at_end", 32'(tr_lvl[b1]), 32'd0);
        end else begin
            check("t1_end_found", 32'(b1), 32'd161);
        end
        check("t1_tx_idle", 32'({tx, tx_busy, tx_empty}), 32'b101);

        // 7E1 loopback of 0x55 and 0x7F
        data_bits = 2'b10; parity = 2'b01; loop = 1'b1;
        write_tx(8'h55);
        write_tx(8'h7F);
        for (int i = 0; i < 1000 && rx_level != 3'd2; i++) step();
        check("t2_rx_level", 32'(rx_level), 32'd2);
        check("t2_head0", 32'({r_frame_err, r_parity_err, r_data}), 32'h055);
        read_rx();
        check("t2_head1", 32'({r_frame_err, r_parity_err, r_data}), 32'h07F);
        read_rx();
        check("t2_empty", 32'(rx_empty), 32'd1);
        wait_tx_idle(400);

        // 7E1 with a wrong parity bit on 0x55 (correct even bit is 0)
        loop = 1'b0; rx_drv = 1'b1;
        repeat (4) step();
        send_frame(8'h55, 7, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 50 && rx_empty; i++) step();
        check("t2_bad_par", 32'({r_frame_err, r_parity_err, r_data}), 32'h155);
        read_rx();

        // 8N1 0x3C with a low stop bit, line held low afterwards
        data_bits = 2'b11; parity = 2'b00;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
        repeat (200) step();
        check("t3_level_low", 32'(rx_level), 32'd1);
        check("t3_head", 32'({r_frame_err, r_parity_err, r_data}), 32'h23C);
        rx_drv = 1'b1;
        repeat (20) step();
        check("t3_level_high", 32'(rx_level), 32'd1);
        read_rx();
        check("t3_empty", 32'(rx_empty), 32'd1);

        // Loopback five characters into a 4-deep RX FIFO without reading
        loop = 1'b1;
        for (int k = 1; k <= 4; k++) write_tx(8'(k));
        check("t4_tx_full", 32'({tx_full, tx_level}), 32'({1'b1, 3'd4}));
        for (int i = 0; i < 400 && tx_full; i++) step();
        write_tx(8'h05);
        wait_tx_idle(2000);
        repeat (4) step();
        check("t4_rx_state", 32'({rx_full, rx_overrun, rx_level}), 32'({1'b1, 1'b1, 3'd4}));
        for (int k = 1; k <= 4; k++) begin
            check("t4_read", 32'(r_data), 32'(k));
            read_rx();
        end
        check("t4_empty_sticky", 32'({rx_empty, rx_overrun}), 32'b11);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        check("t4_clr_err", 32'(rx_overrun), 32'd0);

        // Five back-to-back writes, two stop bits
        stop2 = 1'b1;
        for (int k = 0; k < 4; k++) write_tx(8'h10 + 8'(k));
        check("t5_full_after4", 32'({tx_full, tx_level}), 32'({1'b1, 3'd4}));
        write_tx(8'h14);
        check("t5_level_after5", 32'(tx_level), 32'd4);
        capture(400);
        maxrun = 0; run = 0;
        for (int i = 0; i < 400; i++) begin
            if (tr_tx[i]) run++;
            else begin
                if (run > maxrun) maxrun = run;
                run = 0;
            end
        end
        // Two stop bits plus the single idle clock before the next load.
        checks++;
        assert (maxrun >= 2 * OVS && maxrun <= 2 * OVS + 1) else begin
            errors++;
            $error("FAIL t5_stop2_gap: observed %0d expected %0d..%0d", maxrun, 2 * OVS, 2 * OVS + 1);
        end
        wait_tx_idle(1000);
        repeat (4) step();
        check("t5_rx_state", 32'({rx_overrun, rx_level}), 32'({1'b0, 3'd4}));
        for (int k = 0; k < 4; k++) begin
            check("t5_read", 32'(r_data), 32'h10 + 32'(k));
            read_rx();
        end
        check("t5_no_0x14", 32'(rx_empty), 32'd1);

        // Reset in the middle of a TX/RX data phase
        stop2 = 1'b0;
        write_tx(8'h00);
        repeat (70) step();
        check("t6_pre_reset", 32'({tx, tx_level}), 32'({1'b0, 3'd1}));
        reset = 1'b1;
        #1;
        check("t6_reset_tx", 32'({tx, tx_busy}), 32'b10);
        check("t6_reset_lvls", 32'({tx_level, rx_level, rx_empty}), 32'({3'd0, 3'd0, 1'b1}));
        step();
        reset = 1'b0;
        repeat (200) step();
        check("t6_partial_dropped", 32'(rx_empty), 32'd1);
        write_tx(8'h5A);
        for (int i = 0; i < 400 && rx_empty; i++) step();
        check("t6_post_reset", 32'({r_frame_err, r_parity_err, r_data}), 32'h05A);
        read_rx();
        wait_tx_idle(400);

        // One-clock low glitch on rx
        loop = 1'b0; rx_drv = 1'b1;
        step();
        rx_drv = 1'b0;
        step();
        rx_drv = 1'b1;
        lim = 40;
        repeat (lim) step();
        check("t6_glitch", 32'({rx_empty, rx_level}), 32'({1'b1, 3'd0}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
